// File: rtl/adder_arb_pkg.sv
// Shared types and default sizing for the adder arbiter slice.
// Round-robin arbitration is enabled by defining ADDER_ARB_RR_EN.
package adder_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: grants the first requester found when searching upward from ptr, wrapping.
// A ptr tied to zero degenerates into lowest-index-first fixed priority.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic found;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        // First pass covers ptr..NREQ-1, second pass wraps over 0..ptr-1.
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Several requesters share one adder and a single-entry result register with 1-cycle latency.
// Define ADDER_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [W:0]              rsp_sum,
    output logic [$clog2(NREQ)-1:0] rsp_id
);

    localparam int IW = $clog2(NREQ);

    state_e          state, state_nxt;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   ptr;
    logic            accept;
    logic            xfer;
    logic [W-1:0]    sel_a, sel_b;
    logic [IW-1:0]   sel_id;
    logic [W:0]      sum_nxt;

    rr_arbiter #(.NREQ(NREQ), .PW(IW)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    // The register can take a new sum when empty or when its current sum leaves this cycle.
    assign accept    = (state == ST_EMPTY) || rsp_ready;
    assign req_ready = (accept && !rst) ? gnt : '0;
    assign xfer      = |(req_valid & req_ready);
    assign rsp_valid = (state == ST_FULL);

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_id = IW'(i);
            end
        end
    end

    assign sum_nxt = {1'b0, sel_a} + {1'b0, sel_b};

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            state_nxt = ST_FULL;
        end else if ((state == ST_FULL) && rsp_ready) begin
            state_nxt = ST_EMPTY;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            rsp_sum <= '0;
            rsp_id  <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                rsp_sum <= sum_nxt;
                rsp_id  <= sel_id;
            end
        end
    end

`ifdef ADDER_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (sel_id == IW'(NREQ - 1)) ? '0 : sel_id + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a transaction-level model is checked every cycle,
// plus hand-computed literal expectations along the scenario.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W:0]        rsp_sum;
    logic [1:0]        rsp_id;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: what the result register must hold, at transaction level.
    bit m_full = 1'b0;
    int m_sum  = 0;
    int m_id   = 0;
    int m_ptr  = 0;

    adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic set_all();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 3, 2 * i + 5);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Compare process: outputs vs model mid-cycle, then advance the model across the coming edge.
    always @(negedge clk) begin : model
        logic [NREQ-1:0] exp_ready;
        int              g;
        if (chk_en) begin
            exp_ready = '0;
            g = -1;
            if (!rst && (!m_full || rsp_ready)) begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            check("m_req_ready", 32'(req_ready), 32'(exp_ready));
            check("m_rsp_valid", 32'(rsp_valid), 32'(m_full));
            if (m_full) begin
                check("m_rsp_sum", 32'(rsp_sum), 32'(m_sum));
                check("m_rsp_id", 32'(rsp_id), 32'(m_id));
            end
            if (rst) begin
                m_full = 1'b0;
                m_ptr  = 0;
            end else if (g >= 0) begin
                m_full = 1'b1;
                m_sum  = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
                m_id   = g;
`ifdef ADDER_ARB_RR_EN
                m_ptr  = (g + 1) % NREQ;
`endif
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset values
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_sum", 32'(rsp_sum), 32'h0);
        check("rst_id", 32'(rsp_id), 32'h0);

        // Single requester 0: 1 + 1
        cyc();
        rst = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 1, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        @(negedge clk);
        check("single_valid", 32'(rsp_valid), 32'h1);
        check("single_sum", 32'(rsp_sum), 32'd2);
        check("single_id", 32'(rsp_id), 32'd0);

        // Carry-out: requester 2, 15 + 1
        cyc();
        req_valid = 4'b0100;
        set_op(2, 15, 1);
        @(negedge clk);
        check("carry_ready", 32'(req_ready), 32'b0100);

        // Backpressure for 5 cycles with everyone requesting
        cyc();
        req_valid = 4'b1111;
        set_all();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("carry_sum", 32'(rsp_sum), 32'b10000);
        check("carry_id", 32'(rsp_id), 32'd2);
        check("bp_ready0", 32'(req_ready), 32'h0);
        repeat (4) cyc();
        @(negedge clk);
        check("bp_ready", 32'(req_ready), 32'h0);
        check("bp_sum", 32'(rsp_sum), 32'b10000);
        check("bp_id", 32'(rsp_id), 32'd2);

        // Drain and refill in the same cycle: requester 1, 7 + 9
        cyc();
        req_valid = 4'b0010;
        set_op(1, 7, 9);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("replace_ready", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = '0;
        @(negedge clk);
        check("replace_valid", 32'(rsp_valid), 32'h1);
        check("replace_sum", 32'(rsp_sum), 32'd16);
        check("replace_id", 32'(rsp_id), 32'd1);
        cyc();
        @(negedge clk);
        check("drain_valid", 32'(rsp_valid), 32'h0);

        // Mid-operation reset while FULL
        cyc();
        req_valid = 4'b0001;
        set_op(0, 2, 3);
        cyc();
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_sum", 32'(rsp_sum), 32'd5);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("in_rst_ready", 32'(req_ready), 32'h0);
        cyc();
        rst = 1'b0;
        set_all();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(rsp_valid), 32'h0);
        check("post_rst_ready", 32'(req_ready), 32'b0001);

`ifdef ADDER_ARB_RR_EN
        // Round-robin: grants 0,1,2,3,0 with one response per cycle
        for (int k = 1; k <= 4; k++) begin
            cyc();
            @(negedge clk);
            check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            check("rr_id", 32'(rsp_id), 32'(k - 1));
            check("rr_valid", 32'(rsp_valid), 32'h1);
        end
`else
        // Fixed priority: requester 1 always beats requester 3
        cyc();
        req_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("fp_ready", 32'(req_ready), 32'b0010);
            cyc();
        end
        @(negedge clk);
        check("fp_id", 32'(rsp_id), 32'd1);
        check("fp_sum", 32'(rsp_sum), 32'd11);
`endif

        cyc();
        req_valid = '0;
        repeat (2) cyc();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, is the number of requesters sharing the adder (2..8).
REQ-002 Parameter W, default 4, is the operand width in bits; the sum is W+1 bits.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset: synchronous, active-high.
REQ-005 Port req_valid  input  NREQ  carries one add-request valid bit per requester.
REQ-006 Port req_a  input  NREQ*W  carries the packed operand A per requester; requester i occupies bits [i*W +: W].
REQ-007 Port req_b  input  NREQ*W  carries the packed operand B per requester, packed as req_a.
REQ-008 Port req_ready  output  NREQ  is the one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 Port rsp_valid  output  1  indicates the result register holds a sum.
REQ-010 Port rsp_ready  input  1  indicates the consumer accepts the result.
REQ-011 Port rsp_sum  output  W+1  carries the unsigned sum a+b including the carry-out.
REQ-012 Port rsp_id  output  clog2(NREQ)  carries the index of the requester that owns rsp_sum.

Function
REQ-013 The block shall contain exactly one W-bit adder shared by all requesters.
REQ-014 The block shall hold one result register with two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 In EMPTY, and in FULL when rsp_ready=1, the block shall grant at most one requester with req_valid high; req_ready shall be combinational from req_valid, the state and the priority pointer.
REQ-016 In FULL with rsp_ready=0, req_ready shall be all zero.
REQ-017 On a transfer, rsp_sum shall equal zero-extended a plus zero-extended b, and rsp_id shall equal the granted index; rsp_valid shall rise on the next edge (latency 1 cycle).
REQ-018 A simultaneous drain (rsp_ready=1) and new transfer in FULL shall replace the result, with no bubble; sustained throughput is 1 add per cycle.
REQ-019 A drain without a new transfer shall move FULL to EMPTY.
REQ-020 While rsp_valid=1 and rsp_ready=0, rsp_sum and rsp_id shall hold stable.
REQ-021 Overflow needs no special handling: 15+1 with W=4 gives 5'b10000, and the carry is never lost.
REQ-022 A requester that is not granted shall not be consumed; its request remains pending.

Reset
REQ-023 While rst=1: rsp_valid=0, rsp_sum=0, rsp_id=0, and the priority pointer is 0.
REQ-024 req_ready shall be all zero during reset.
REQ-025 Asserting reset mid-operation shall discard any held result without emitting a response.

Configuration
REQ-026 With ADDER_ARB_RR_EN defined, arbitration shall be round-robin: the search starts at pointer p, and after a grant to index g, p becomes (g+1) mod NREQ.
REQ-027 Without ADDER_ARB_RR_EN, arbitration shall be fixed priority with the lowest index first, and the pointer shall not be implemented.

Structure
REQ-028 A shared package adder_arb_pkg shall hold the state enum (ST_EMPTY, ST_FULL) and the default constants for NREQ and W.
REQ-029 The arbiter shall be a sub-module rr_arbiter (inputs req/ptr, output one-hot gnt); the adder and result register shall stay in adder_arbiter.

Verification
REQ-030 Reset then a single requester: after rst, req_valid=4'b0001, a=1, b=1 -> req_ready=4'b0001, and next cycle rsp_valid=1, rsp_sum=2, rsp_id=0.
REQ-031 Carry-out: requester 2 sends a=15, b=1 -> rsp_sum=5'b10000, rsp_id=2.
REQ-032 Round-robin fairness (RR_EN): all four requesters held valid and rsp_ready=1 -> grants go 0,1,2,3,0 on consecutive cycles, one response per cycle.
REQ-033 Fixed priority (no RR_EN): requesters 1 and 3 held valid -> requester 1 is granted every cycle and 3 never.
REQ-034 Backpressure: result FULL with rsp_ready=0 for 5 cycles -> req_ready=0 and rsp_sum/rsp_id stable; then rsp_ready=1 with a new request -> the result is replaced in the same cycle.
REQ-035 Mid-operation reset: rst asserted while FULL -> next cycle rsp_valid=0, and the pointer restarts at requester 0.
